hisoc_test_seq: RTL

Synthesizable multi-test sequencer and pass/fail monitor for HISOC regression runs. It steps through `TEST_NUM` instruction images: it resets the core, requests each image load, then releases and enables the core. It judges each test by snooping register-file writes to x26 (done), x27 (pass) and x3 (gp/testnum) on up to `HART_NUM` harts. It sits beside `HISOC`, driving core reset/enable and the image-loader handshake, and reports per-test results and aggregate counts.

---
 rtl/hisoc_test_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hisoc_test_seq.sv
// rtl/hisoc_test_seq.sv - multi-test sequencer and pass/fail monitor for HISOC regression runs
// Walks TEST_NUM images through reset/load/warm/run and judges each by snooping x26/x27/x3 writes.
module hisoc_test_seq #(
   parameter int CPU_WIDTH   = 32,
   parameter int HART_NUM    = 1,
   parameter int TEST_NUM    = 37,
   parameter int IDX_W       = 6,
   parameter int RST_CYC     = 1,
   parameter int WARM_CYC    = 5,
   parameter int SETTLE_CYC  = 4,
   parameter int TO_W        = 20,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          stop_on_fail,
   input  logic [HART_NUM-1:0]           rf_wen,
   input  logic [5*HART_NUM-1:0]         rf_waddr,
   input  logic [CPU_WIDTH*HART_NUM-1:0] rf_wdata,
   output logic                          load_req,
   input  logic                          load_ack,
   output logic [IDX_W-1:0]              test_idx,
   output logic                          core_rst_n,
   output logic                          core_enable,
   output logic                          busy,
   output logic                          res_valid,
   output logic                          res_pass,
   output logic                          res_timeout,
   output logic [CPU_WIDTH-1:0]          res_gp,
   output logic [IDX_W-1:0]              pass_cnt,
   output logic [IDX_W-1:0]              fail_cnt,
   output logic                          run_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_LOAD, S_WARM, S_RUN, S_SETTLE, S_EVAL, S_DONE
   } state_t;

   localparam logic [TO_W-1:0]  RST_LAST    = TO_W'(RST_CYC - 1);
   localparam logic [TO_W-1:0]  WARM_LAST   = TO_W'(WARM_CYC - 1);
   localparam logic [TO_W-1:0]  SETTLE_LAST = TO_W'(SETTLE_CYC - 1);
   localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [IDX_W-1:0] LAST_TEST   = IDX_W'(TEST_NUM - 1);

   state_t               state, next_state;
   logic [TO_W-1:0]      cnt;
   logic                 timeout_q;
   logic                 sof_q;
   logic [HART_NUM-1:0]  done_f;
   logic [HART_NUM-1:0]  pass_f;
   logic [CPU_WIDTH-1:0] gp_f [HART_NUM];
   logic                 snoop_en;
   logic                 to_hit;
   logic                 eval_pass;
   logic [CPU_WIDTH-1:0] fail_gp;

   always_comb begin
      snoop_en  = state inside {S_WARM, S_RUN, S_SETTLE};
      to_hit    = (state == S_RUN) && (cnt == TO_LAST);
      eval_pass = (&pass_f) && !timeout_q;
      fail_gp   = '0;
      // descending scan so the lowest-numbered failing hart wins
      for (int h = HART_NUM - 1; h >= 0; h--) begin
         if (!pass_f[h]) fail_gp = gp_f[h];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_DONE: if (start) next_state = S_RST;
         S_RST:          if (cnt == RST_LAST) next_state = S_LOAD;
         S_LOAD:         if (load_ack) next_state = S_WARM;
         S_WARM:         if (cnt == WARM_LAST) next_state = S_RUN;
         S_RUN: begin
            // timeout is checked first so it wins a tie with the last done
            if (to_hit)        next_state = S_EVAL;
            else if (&done_f)  next_state = S_SETTLE;
         end
         S_SETTLE:       if (cnt == SETTLE_LAST) next_state = S_EVAL;
         S_EVAL: begin
            if (test_idx == LAST_TEST || (!eval_pass && sof_q)) next_state = S_DONE;
            else                                                next_state = S_RST;
         end
         default:        next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_f <= '0;
         pass_f <= '0;
         for (int h = 0; h < HART_NUM; h++) gp_f[h] <= '0;
      end else if (state == S_RST) begin
         done_f <= '0;
         pass_f <= '0;
         for (int h = 0; h < HART_NUM; h++) gp_f[h] <= '0;
      end else if (snoop_en) begin
         for (int h = 0; h < HART_NUM; h++) begin
            if (rf_wen[h]) begin
               case (rf_waddr[5*h +: 5])
                  5'd26:   done_f[h] <= (rf_wdata[CPU_WIDTH*h +: CPU_WIDTH] == CPU_WIDTH'(1));
                  5'd27:   pass_f[h] <= (rf_wdata[CPU_WIDTH*h +: CPU_WIDTH] == CPU_WIDTH'(1));
                  5'd3:    gp_f[h]   <= rf_wdata[CPU_WIDTH*h +: CPU_WIDTH];
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         timeout_q   <= 1'b0;
         sof_q       <= 1'b0;
         load_req    <= 1'b0;
         test_idx    <= '0;
         core_rst_n  <= 1'b0;
         core_enable <= 1'b0;
         busy        <= 1'b0;
         res_valid   <= 1'b0;
         res_pass    <= 1'b0;
         res_timeout <= 1'b0;
         res_gp      <= '0;
         pass_cnt    <= '0;
         fail_cnt    <= '0;
         run_done    <= 1'b0;
      end else begin
         cnt         <= (next_state != state) ? '0 : cnt + TO_W'(1);
         load_req    <= (state == S_LOAD) && !load_ack;
         core_rst_n  <= state inside {S_WARM, S_RUN, S_SETTLE, S_EVAL};
         core_enable <= state inside {S_RUN, S_SETTLE};
         busy        <= !(state inside {S_IDLE, S_DONE});
         run_done    <= (state == S_DONE);
         res_valid   <= (state == S_EVAL);
         if (state == S_RST) timeout_q <= 1'b0;
         else if (to_hit)    timeout_q <= 1'b1;
         if ((state == S_IDLE || state == S_DONE) && start) begin
            test_idx <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            sof_q    <= stop_on_fail;
         end
         if (state == S_EVAL) begin
            res_pass    <= eval_pass;
            res_timeout <= timeout_q;
            res_gp      <= eval_pass ? '0 : fail_gp;
            if (eval_pass) pass_cnt <= pass_cnt + IDX_W'(1);
            else           fail_cnt <= fail_cnt + IDX_W'(1);
            if (next_state == S_RST) test_idx <= test_idx + IDX_W'(1);
         end
      end
   end

endmodule
